// File: rtl/krnl_vadd_rtl_xfer_sched.sv
// Transfer scheduler for the vadd RTL kernel: splits a job into chunk-sized read/write
// commands, bounds outstanding reads, and releases each write only after its read lands.
module krnl_vadd_rtl_xfer_sched #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_SIZE_WIDTH      = 32,
  parameter int C_CHUNK_BYTES     = 4096,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           ap_start,
  output logic                           ap_idle,
  output logic                           ap_done,
  output logic                           err,
  input  logic [C_SIZE_WIDTH-1:0]        size_in_bytes,
  input  logic [C_ADDR_WIDTH-1:0]        src_ptr,
  input  logic [C_ADDR_WIDTH-1:0]        dst_ptr,
  output logic                           rd_cmd_valid,
  input  logic                           rd_cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]        rd_cmd_addr,
  output logic [$clog2(C_CHUNK_BYTES):0] rd_cmd_len,
  input  logic                           rd_done,
  output logic                           wr_cmd_valid,
  input  logic                           wr_cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]        wr_cmd_addr,
  output logic [$clog2(C_CHUNK_BYTES):0] wr_cmd_len,
  input  logic                           wr_done
);

  localparam int CB_LOG2 = $clog2(C_CHUNK_BYTES);
  localparam int LEN_W   = CB_LOG2 + 1;
  localparam logic [LEN_W-1:0]        FULL_LEN = LEN_W'(C_CHUNK_BYTES);
  localparam logic [C_SIZE_WIDTH-1:0] MAX_OUT  = C_SIZE_WIDTH'(C_MAX_OUTSTANDING);
  localparam logic [C_SIZE_WIDTH-1:0] ONE      = C_SIZE_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t                  state;
  logic [C_SIZE_WIDTH-1:0] size_r, n_chunks;
  logic [C_SIZE_WIDTH-1:0] rd_issued, rd_cmpl, wr_issued, wr_cmpl;
  logic [LEN_W-1:0]        last_len;
  logic [C_ADDR_WIDTH-1:0] src_r, dst_r;

  logic                    rd_hs, wr_hs, rd_done_ok, wr_done_ok, proto_err;
  logic [C_SIZE_WIDTH-1:0] rd_issued_n, rd_cmpl_n, wr_issued_n, wr_cmpl_n;
  logic [CB_LOG2-1:0]      size_rem;

  function automatic logic [C_SIZE_WIDTH-1:0] bump(input logic [C_SIZE_WIDTH-1:0] cnt,
                                                   input logic en);
    return cnt + {{(C_SIZE_WIDTH-1){1'b0}}, en};
  endfunction

  function automatic logic [C_ADDR_WIDTH-1:0] chunk_addr(input logic [C_ADDR_WIDTH-1:0] base,
                                                         input logic [C_SIZE_WIDTH-1:0] idx);
    logic [C_ADDR_WIDTH-1:0] off;
    off = C_ADDR_WIDTH'(idx) << CB_LOG2;
    return base + off;
  endfunction

  function automatic logic [LEN_W-1:0] chunk_len(input logic [C_SIZE_WIDTH-1:0] idx,
                                                 input logic [C_SIZE_WIDTH-1:0] n,
                                                 input logic [LEN_W-1:0]        last);
    return (idx == n - ONE) ? last : FULL_LEN;
  endfunction

  // Counter values as they will stand after this edge; command decisions look ahead
  // so a freed slot or newly landed read is used on the very next cycle.
  always_comb begin
    rd_hs       = rd_cmd_valid & rd_cmd_ready;
    wr_hs       = wr_cmd_valid & wr_cmd_ready;
    rd_done_ok  = rd_done && (rd_issued != rd_cmpl);
    wr_done_ok  = wr_done && (wr_issued != wr_cmpl);
    proto_err   = (rd_done && !rd_done_ok) || (wr_done && !wr_done_ok);
    rd_issued_n = bump(rd_issued, rd_hs);
    wr_issued_n = bump(wr_issued, wr_hs);
    rd_cmpl_n   = bump(rd_cmpl, rd_done_ok);
    wr_cmpl_n   = bump(wr_cmpl, wr_done_ok);
    size_rem    = size_r[CB_LOG2-1:0];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      ap_idle      <= 1'b1;
      ap_done      <= 1'b0;
      err          <= 1'b0;
      size_r       <= '0;
      src_r        <= '0;
      dst_r        <= '0;
      n_chunks     <= '0;
      last_len     <= '0;
      rd_issued    <= '0;
      rd_cmpl      <= '0;
      wr_issued    <= '0;
      wr_cmpl      <= '0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_len   <= '0;
      wr_cmd_valid <= 1'b0;
      wr_cmd_addr  <= '0;
      wr_cmd_len   <= '0;
    end else begin
      if (state != IDLE) begin
        rd_issued <= rd_issued_n;
        rd_cmpl   <= rd_cmpl_n;
        wr_issued <= wr_issued_n;
        wr_cmpl   <= wr_cmpl_n;
        if (proto_err) err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ap_start) begin
            size_r    <= size_in_bytes;
            src_r     <= src_ptr;
            dst_r     <= dst_ptr;
            rd_issued <= '0;
            rd_cmpl   <= '0;
            wr_issued <= '0;
            wr_cmpl   <= '0;
            err       <= 1'b0;
            ap_idle   <= 1'b0;
            state     <= INIT;
          end else if (rd_done || wr_done) begin
            err <= 1'b1;
          end
        end
        INIT: begin
          n_chunks <= (size_r >> CB_LOG2) + {{(C_SIZE_WIDTH-1){1'b0}}, |size_rem};
          last_len <= (size_rem == '0) ? FULL_LEN : {1'b0, size_rem};
          if (size_r == '0) begin
            ap_done <= 1'b1;
            state   <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (wr_cmpl_n == n_chunks) begin
            rd_cmd_valid <= 1'b0;
            wr_cmd_valid <= 1'b0;
            ap_done      <= 1'b1;
            state        <= DONE;
          end else begin
            // A presented command is frozen until accepted.
            if (!rd_cmd_valid || rd_cmd_ready) begin
              rd_cmd_valid <= (rd_issued_n < n_chunks) && ((rd_issued_n - rd_cmpl_n) < MAX_OUT);
              rd_cmd_addr  <= chunk_addr(src_r, rd_issued_n);
              rd_cmd_len   <= chunk_len(rd_issued_n, n_chunks, last_len);
            end
            if (!wr_cmd_valid || wr_cmd_ready) begin
              wr_cmd_valid <= wr_issued_n < rd_cmpl_n;
              wr_cmd_addr  <= chunk_addr(dst_r, wr_issued_n);
              wr_cmd_len   <= chunk_len(wr_issued_n, n_chunks, last_len);
            end
          end
        end
        DONE: begin
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/krnl_vadd_rtl_xfer_sched.md
# krnl_vadd_rtl_xfer_sched

Transfer scheduler for the vadd RTL kernel. It sits between the AXI4-Lite control slave (ap_start, size_in_bytes, source/destination pointers) and the AXI master read/write engines. It splits a job into fixed-size burst chunks, issues read and write commands with a bounded number of outstanding reads, and releases each write only once its read data has landed. When every write has completed, it returns ap_done/ap_idle to the control slave.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, pointer/command address width
- C_SIZE_WIDTH, 32, width of size_in_bytes
- C_CHUNK_BYTES, 4096, chunk size in bytes; power of two, ≥64
- C_MAX_OUTSTANDING, 4, maximum read commands issued but not yet completed; 1..15

Ports:
- aclk  in  1  kernel clock; single clock domain
- areset  in  1  asynchronous, active-high reset
- ap_start  in  1  level from control slave; held high until ap_done
- ap_idle  out  1  high when no job is active
- ap_done  out  1  one-cycle completion pulse
- err  out  1  sticky protocol error; cleared at next job start
- size_in_bytes  in  C_SIZE_WIDTH  job length; sampled at start
- src_ptr  in  C_ADDR_WIDTH  read base; sampled at start
- dst_ptr  in  C_ADDR_WIDTH  write base; sampled at start
- rd_cmd_valid / rd_cmd_ready  out/in  1  read command handshake
- rd_cmd_addr  out  C_ADDR_WIDTH  chunk byte address
- rd_cmd_len  out  log2(C_CHUNK_BYTES)+1  chunk length in bytes
- rd_done  in  1  one pulse per completed read command, in issue order
- wr_cmd_valid / wr_cmd_ready  out/in  1  write command handshake
- wr_cmd_addr  out  C_ADDR_WIDTH  chunk byte address
- wr_cmd_len  out  log2(C_CHUNK_BYTES)+1  chunk length in bytes
- wr_done  in  1  one pulse per completed write command

## Operation
- Reset values: ap_idle=1, ap_done=0, err=0, rd_cmd_valid=0, wr_cmd_valid=0. Addresses, lengths and all counters are 0. State is IDLE.
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE → INIT when ap_start=1.
  - Latch size, src_ptr and dst_ptr. Clear err and all counters.
  - ap_idle drops on the INIT entry edge.
- INIT:
  - Compute N = ceil(size / C_CHUNK_BYTES) and the last-chunk length L = size mod C_CHUNK_BYTES, or C_CHUNK_BYTES if that remainder is 0.
  - If size=0: go to DONE. Otherwise go to RUN.
- RUN, read issue:
  - rd_cmd_valid=1 when rd_issued<N and (rd_issued − rd_cmpl) < C_MAX_OUTSTANDING.
  - Address = src + rd_issued·C_CHUNK_BYTES. Length = L for chunk N−1, otherwise C_CHUNK_BYTES.
  - Once valid is asserted, valid, address and length hold stable until ready.
- RUN, write issue:
  - wr_cmd_valid=1 when wr_issued < rd_cmpl.
  - Address and length follow the same rule as reads, applied to dst and the write index. Valid, address and length hold until ready.
- Reads and writes are independent. Both handshakes may complete in the same cycle.
- RUN → DONE when wr_cmpl = N.
- DONE: ap_done=1 for exactly one cycle, then IDLE (ap_idle=1 on that edge). The control slave clears ap_start on ap_done, so no restart occurs.
- Counters are C_SIZE_WIDTH wide. A command handshake and a done pulse in the same cycle both count.
- Protocol errors set err and are otherwise ignored (the counter does not move):
  - rd_done while rd_issued=rd_cmpl.
  - wr_done while wr_issued=wr_cmpl.
  - Any done pulse in IDLE.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH. Pointers are host-guaranteed C_CHUNK_BYTES aligned; this is not checked.
- areset mid-job: immediate return to IDLE with reset values. In-flight downstream commands are not tracked.

## Timing
- ap_start seen high at edge t: INIT from t+1; first rd_cmd_valid visible after edge t+2.
- Command outputs are registered, so a new command appears the cycle after the previous handshake. Sustained rate is one command per cycle per channel.
- A write becomes eligible the cycle after the rd_done that enables it.
- ap_done asserts the cycle after the final wr_done.
- size=0: ap_done is high during cycle t+2, and no commands are issued.

## Test plan
- size=0, src=0x1000, dst=0x8000 → no rd/wr commands; ap_done high exactly one cycle; ap_idle high again next cycle.
- size=10000, C_CHUNK_BYTES=4096, src=0x10000, dst=0x40000, all readies high, done pulses 3 cycles after each handshake:
  - reads: (0x10000,4096), (0x11000,4096), (0x12000,1808)
  - writes: same lengths at 0x40000, 0x41000, 0x42000
  - one ap_done.
- size=32768, rd_done withheld → exactly 4 reads issued, then rd_cmd_valid stays low. Releasing one rd_done issues read 5 and write 1.
- rd_cmd_ready low for 5 cycles during the second command → rd_cmd_valid, address and length held stable throughout; no duplicate or dropped command.
- Stray wr_done in IDLE → err=1, counters unchanged. A subsequent ap_start clears err.
- areset pulsed after 2 reads issued → all outputs return to reset values asynchronously. A following job with size=4096 runs cleanly: one read, one write, ap_done.
